// File: rtl/ascon_pack.sv
// Shared state type and round-index constants for the ASCON-128 encryption controller.
package ascon_pack;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_AD,
        AD,
        WAIT_PT,
        PT,
        FINAL,
        DONE
    } type_ctrl_state;

    localparam logic [3:0] ROUND_A_START = 4'd0;
    localparam logic [3:0] ROUND_B_START = 4'd6;
    localparam logic [3:0] ROUND_LAST    = 4'd11;

endpackage

// File: rtl/round_counter.sv
// Permutation round index: reloads with a start index, steps once per enabled cycle,
// and flags the last round of the current permutation.
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic [3:0] last_val,
    output logic [3:0] count,
    output logic       last
);

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != ROUND_LAST)) begin
            // Saturate at the final constant index so round_o never leaves 0..11.
            count <= count + 4'd1;
        end
    end

    assign last = (count == last_val);

endmodule

// File: rtl/ascon_enc_ctrl.sv
// Sequencing FSM for the ASCON-128 encryption datapath (init, one AD block, NB_PT PT blocks, final).
// Define ASCON_CTRL_ASSERT_EN to embed SVA checks on the control outputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no message; waits for start_i
// INIT    | p^a over IV||K||N, key XORed into S3:S4 on the last round
// WAIT_AD | requests the associated-data block
// AD      | p^b with the AD block, domain-separation bit on the last round
// WAIT_PT | requests the next plaintext block
// PT      | p^b with a plaintext block, ciphertext captured on round one
// FINAL   | p^a with the last PT block, key XOR before and after, tag capture
// DONE    | one-cycle completion pulse
module ascon_enc_ctrl
    import ascon_pack::*;
#(
    parameter int unsigned NB_PT    = 4,
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    output logic       block_req_o,
    output logic [3:0] round_o,
    output logic       sel_init_o,
    output logic       en_reg_state_o,
    output logic       en_xor_data_begin_o,
    output logic       en_xor_key_begin_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [3:0] A_LAST  = 4'(ROUNDS_A - 1);
    localparam logic [3:0] B_START = 4'(32'd12 - ROUNDS_B);
    localparam logic [3:0] BLK_MAX = 4'(NB_PT - 1);

    type_ctrl_state state_q, state_d;

    logic [3:0] round;
    logic       rc_last;
    logic       rc_load;
    logic [3:0] rc_load_val;
    logic       rc_en;
    logic [3:0] rc_last_val;
    logic [3:0] blk_q;
    logic       blk_clr;
    logic       blk_inc;
    logic       first_a;
    logic       first_b;

    round_counter u_round_counter (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .load     (rc_load),
        .load_val (rc_load_val),
        .en       (rc_en),
        .last_val (rc_last_val),
        .count    (round),
        .last     (rc_last)
    );

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            blk_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            if (blk_clr) begin
                blk_q <= 4'd0;
            end else if (blk_inc) begin
                blk_q <= blk_q + 4'd1;
            end
        end
    end

    // p^a ends at ROUNDS_A-1, p^b always ends on the last constant index.
    assign rc_last_val = ((state_q == INIT) || (state_q == FINAL)) ? A_LAST : ROUND_LAST;

    always_comb begin
        state_d     = state_q;
        rc_load     = 1'b0;
        rc_load_val = ROUND_A_START;
        rc_en       = 1'b0;
        blk_clr     = 1'b0;
        blk_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = INIT;
                    rc_load     = 1'b1;
                    rc_load_val = ROUND_A_START;
                end
            end
            INIT: begin
                if (rc_last) state_d = WAIT_AD;
                else         rc_en   = 1'b1;
            end
            WAIT_AD: begin
                if (data_valid_i) begin
                    state_d     = AD;
                    rc_load     = 1'b1;
                    rc_load_val = B_START;
                end
            end
            AD: begin
                if (rc_last) begin
                    state_d = WAIT_PT;
                    blk_clr = 1'b1;
                end else begin
                    rc_en = 1'b1;
                end
            end
            WAIT_PT: begin
                if (data_valid_i) begin
                    rc_load = 1'b1;
                    if (blk_q < BLK_MAX) begin
                        state_d     = PT;
                        rc_load_val = B_START;
                    end else begin
                        state_d     = FINAL;
                        rc_load_val = ROUND_A_START;
                    end
                end
            end
            PT: begin
                if (rc_last) begin
                    state_d = WAIT_PT;
                    blk_inc = 1'b1;
                end else begin
                    rc_en = 1'b1;
                end
            end
            FINAL: begin
                if (rc_last) state_d = DONE;
                else         rc_en   = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign first_a = (round == ROUND_A_START);
    assign first_b = (round == B_START);
    assign round_o = round;

    always_comb begin
        block_req_o         = 1'b0;
        sel_init_o          = 1'b0;
        en_reg_state_o      = 1'b0;
        en_xor_data_begin_o = 1'b0;
        en_xor_key_begin_o  = 1'b0;
        en_xor_key_end_o    = 1'b0;
        en_xor_lsb_o        = 1'b0;
        en_cipher_o         = 1'b0;
        en_tag_o            = 1'b0;
        busy_o              = (state_q != IDLE);
        done_o              = 1'b0;
        case (state_q)
            INIT: begin
                en_reg_state_o   = 1'b1;
                sel_init_o       = first_a;
                en_xor_key_end_o = rc_last;
            end
            WAIT_AD, WAIT_PT: begin
                block_req_o = 1'b1;
            end
            AD: begin
                en_reg_state_o      = 1'b1;
                en_xor_data_begin_o = first_b;
                en_xor_lsb_o        = rc_last;
            end
            PT: begin
                en_reg_state_o      = 1'b1;
                en_xor_data_begin_o = first_b;
                en_cipher_o         = first_b;
            end
            FINAL: begin
                en_reg_state_o      = 1'b1;
                en_xor_data_begin_o = first_a;
                en_cipher_o         = first_a;
                en_xor_key_begin_o  = first_a;
                en_xor_key_end_o    = rc_last;
                en_tag_o            = rc_last;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef ASCON_CTRL_ASSERT_EN
    a_round_max: assert property (@(posedge clock_i) disable iff (!resetb_i)
        round_o <= ROUND_LAST);
    a_end_excl: assert property (@(posedge clock_i) disable iff (!resetb_i)
        !(en_xor_key_end_o && en_xor_lsb_o));
    a_req_no_load: assert property (@(posedge clock_i) disable iff (!resetb_i)
        block_req_o |-> !en_reg_state_o);
    a_done_pulse: assert property (@(posedge clock_i) disable iff (!resetb_i)
        done_o |=> !done_o);
    a_busy_idle: assert property (@(posedge clock_i) disable iff (!resetb_i)
        (!busy_o) == (state_q == IDLE));
`endif

endmodule

// File: tb/tb_ascon_enc_ctrl.sv
// Directed bench for ascon_enc_ctrl at default parameters (NB_PT=4, ROUNDS_A=12, ROUNDS_B=6).
// Cycle n=1 is the first INIT round; counting start_i's own cycle as one, done_o lands in cycle 55 (n=54).
module tb_ascon_enc_ctrl;

    logic       clock_i = 1'b0;
    logic       resetb_i;
    logic       start_i;
    logic       data_valid_i;
    logic       block_req_o;
    logic [3:0] round_o;
    logic       sel_init_o;
    logic       en_reg_state_o;
    logic       en_xor_data_begin_o;
    logic       en_xor_key_begin_o;
    logic       en_xor_key_end_o;
    logic       en_xor_lsb_o;
    logic       en_cipher_o;
    logic       en_tag_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int passes = 0;

    ascon_enc_ctrl dut (
        .clock_i             (clock_i),
        .resetb_i            (resetb_i),
        .start_i             (start_i),
        .data_valid_i        (data_valid_i),
        .block_req_o         (block_req_o),
        .round_o             (round_o),
        .sel_init_o          (sel_init_o),
        .en_reg_state_o      (en_reg_state_o),
        .en_xor_data_begin_o (en_xor_data_begin_o),
        .en_xor_key_begin_o  (en_xor_key_begin_o),
        .en_xor_key_end_o    (en_xor_key_end_o),
        .en_xor_lsb_o        (en_xor_lsb_o),
        .en_cipher_o         (en_cipher_o),
        .en_tag_o            (en_tag_o),
        .busy_o              (busy_o),
        .done_o              (done_o)
    );

    always #5 clock_i = ~clock_i;

    wire [14:0] all_outs = {block_req_o, round_o, sel_init_o, en_reg_state_o, en_xor_data_begin_o,
                            en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o, en_cipher_o,
                            en_tag_o, busy_o, done_o};

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_reset();
        resetb_i     = 1'b0;
        start_i      = 1'b0;
        data_valid_i = 1'b1;
        tick();
        tick();
        resetb_i = 1'b1;
        tick();
    endtask

    // Pulses start_i for one edge; on return the bench sits in cycle n=1.
    task automatic start_msg();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Runs from cycle n0 until done_o, optionally pulsing start_i at cycle pulse_at.
    task automatic run_to_done(input int n0, input int pulse_at,
                               output int done_at, output int ciphers, output int tags);
        int n;
        n       = n0;
        done_at = -1;
        ciphers = 0;
        tags    = 0;
        while (done_at < 0 && n < n0 + 300) begin
            if (en_cipher_o) ciphers++;
            if (en_tag_o)    tags++;
            if (done_o) begin
                done_at = n;
            end else begin
                start_i = (n == pulse_at);
                tick();
                start_i = 1'b0;
                n++;
            end
        end
    endtask

    task automatic test_reset();
        resetb_i     = 1'b0;
        start_i      = 1'b0;
        data_valid_i = 1'b0;
        tick();
        checks++;
        if (all_outs !== 15'd0) $display("FAIL reset_outs: got %h want 0000", all_outs);
        else passes++;
        #2 resetb_i = 1'b1;
        tick();
        tick();
        checks++;
        if (all_outs !== 15'd0) $display("FAIL idle_outs: got %h want 0000", all_outs);
        else passes++;
    endtask

    task automatic test_init_ad();
        do_reset();
        start_msg();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (round_o !== 4'(i) || sel_init_o !== (i == 0) || en_xor_key_end_o !== (i == 11) ||
                en_reg_state_o !== 1'b1 || block_req_o !== 1'b0 || busy_o !== 1'b1)
                $display("FAIL init_round%0d: got round=%0d sel=%b kend=%b reg=%b req=%b busy=%b", i,
                         round_o, sel_init_o, en_xor_key_end_o, en_reg_state_o, block_req_o, busy_o);
            else passes++;
            tick();
        end
        checks++;
        if (block_req_o !== 1'b1 || en_reg_state_o !== 1'b0)
            $display("FAIL wait_ad_n13: got req=%b reg=%b want req=1 reg=0", block_req_o, en_reg_state_o);
        else passes++;
        tick();
        for (int j = 6; j < 12; j++) begin
            checks++;
            if (round_o !== 4'(j) || en_xor_data_begin_o !== (j == 6) || en_xor_lsb_o !== (j == 11) ||
                en_xor_key_end_o !== 1'b0 || en_cipher_o !== 1'b0 || en_reg_state_o !== 1'b1)
                $display("FAIL ad_round%0d: got round=%0d dbeg=%b lsb=%b kend=%b ciph=%b reg=%b", j,
                         round_o, en_xor_data_begin_o, en_xor_lsb_o, en_xor_key_end_o, en_cipher_o,
                         en_reg_state_o);
            else passes++;
            tick();
        end
        checks++;
        if (block_req_o !== 1'b1 || en_reg_state_o !== 1'b0)
            $display("FAIL wait_pt_n20: got req=%b reg=%b want req=1 reg=0", block_req_o, en_reg_state_o);
        else passes++;
    endtask

    task automatic test_full_message();
        int done_at, ciphers, tags;
        do_reset();
        start_msg();
        run_to_done(1, -1, done_at, ciphers, tags);
        checks++;
        if (done_at !== 54) $display("FAIL full_latency: got n=%0d want n=54", done_at);
        else passes++;
        checks++;
        if (ciphers !== 4 || tags !== 1) $display("FAIL full_counts: got cipher=%0d tag=%0d want 4/1", ciphers, tags);
        else passes++;
        tick();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL full_after_done: got busy=%b done=%b want 0/0", busy_o, done_o);
        else passes++;
    endtask

    task automatic test_wait_stall();
        int done_at, ciphers, tags;
        do_reset();
        start_msg();
        for (int n = 1; n < 20; n++) tick();
        data_valid_i = 1'b0;
        checks++;
        if (block_req_o !== 1'b1 || round_o !== 4'd11)
            $display("FAIL stall_entry: got req=%b round=%0d want 1/11", block_req_o, round_o);
        else passes++;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (block_req_o !== 1'b1 || en_reg_state_o !== 1'b0 || round_o !== 4'd11 ||
                en_cipher_o !== 1'b0 || en_xor_data_begin_o !== 1'b0 || busy_o !== 1'b1)
                $display("FAIL stall_cycle%0d: got req=%b reg=%b round=%0d ciph=%b dbeg=%b busy=%b", k,
                         block_req_o, en_reg_state_o, round_o, en_cipher_o, en_xor_data_begin_o, busy_o);
            else passes++;
        end
        data_valid_i = 1'b1;
        tick();
        checks++;
        if (round_o !== 4'd6 || en_cipher_o !== 1'b1 || en_xor_data_begin_o !== 1'b1 || block_req_o !== 1'b0)
            $display("FAIL stall_resume: got round=%0d ciph=%b dbeg=%b req=%b want 6/1/1/0",
                     round_o, en_cipher_o, en_xor_data_begin_o, block_req_o);
        else passes++;
        run_to_done(41, -1, done_at, ciphers, tags);
        checks++;
        if (done_at !== 74 || ciphers !== 4 || tags !== 1)
            $display("FAIL stall_done: got n=%0d cipher=%0d tag=%0d want 74/4/1", done_at, ciphers, tags);
        else passes++;
    endtask

    task automatic test_reset_in_final();
        int done_at, ciphers, tags;
        bit saw_done;
        do_reset();
        start_msg();
        saw_done = 1'b0;
        for (int n = 1; n < 47; n++) begin
            if (done_o) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (round_o !== 4'd5 || en_reg_state_o !== 1'b1 || block_req_o !== 1'b0)
            $display("FAIL final_round5: got round=%0d reg=%b req=%b want 5/1/0", round_o, en_reg_state_o, block_req_o);
        else passes++;
        resetb_i = 1'b0;
        #1;
        checks++;
        if (all_outs !== 15'd0) $display("FAIL abort_outs: got %h want 0000", all_outs);
        else passes++;
        #2 resetb_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (done_o || busy_o) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done !== 1'b0 || busy_o !== 1'b0) $display("FAIL abort_no_done: got done_or_busy=%b busy=%b want 0/0", saw_done, busy_o);
        else passes++;
        start_msg();
        run_to_done(1, -1, done_at, ciphers, tags);
        checks++;
        if (done_at !== 54 || ciphers !== 4 || tags !== 1)
            $display("FAIL after_abort: got n=%0d cipher=%0d tag=%0d want 54/4/1", done_at, ciphers, tags);
        else passes++;
    endtask

    task automatic test_start_during_pt();
        int done_at, ciphers, tags;
        do_reset();
        start_msg();
        run_to_done(1, 22, done_at, ciphers, tags);
        checks++;
        if (done_at !== 54 || ciphers !== 4 || tags !== 1)
            $display("FAIL start_in_pt: got n=%0d cipher=%0d tag=%0d want 54/4/1", done_at, ciphers, tags);
        else passes++;
        tick();
        checks++;
        if (busy_o !== 1'b0) $display("FAIL start_in_pt_idle: got busy=%b want 0", busy_o);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_init_ad();
        test_full_message();
        test_wait_stall();
        test_reset_in_final();
        test_start_during_pt();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
